seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/seq_div.sv | 144 ++++++++++++++
 tb/tb_seq_div.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- sequential restoring unsigned divider
//
// The divider produces one quotient bit per clock, MSB first. An operation is
// accepted in IDLE when i_valid is high. It then spends alu_width cycles in
// RUN and one cycle in DONE, where o_valid pulses, before returning to IDLE.
//
// Ports
//   clk       : single clock; all state changes happen on its rising edge
//   rst       : asynchronous, active-low reset
//   i_data_a  : dividend (unsigned), latched on the accepting edge
//   i_data_b  : divisor  (unsigned), latched on the accepting edge
//   i_valid   : single-cycle operand strobe; honoured only in IDLE
//   o_ready   : high in IDLE (combinational from state)
//   o_data    : quotient; holds the last result until the next completion
//   o_rem     : remainder; holds the last result until the next completion
//   o_valid   : one-cycle result strobe (the DONE state)
//   o_dbz     : divide-by-zero flag, qualified by o_valid
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int alu_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [alu_width-1:0] i_data_a,
  input  logic [alu_width-1:0] i_data_b,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [alu_width-1:0] o_data,
  output logic [alu_width-1:0] o_rem,
  output logic                 o_valid,
  output logic                 o_dbz
);

  localparam int cnt_w = $clog2(alu_width) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [cnt_w-1:0]     cnt_reg;
  logic [alu_width:0]   rem_reg;   // partial remainder, one guard bit wide
  logic [alu_width-1:0] quo_reg;   // dividend bits shift out, quotient bits shift in
  logic [alu_width-1:0] div_reg;

  logic [alu_width+1:0] shifted;
  logic [alu_width:0]   diff;
  logic                 trial_neg;
  logic [alu_width:0]   rem_next;
  logic [alu_width-1:0] quo_next;
  logic                 last_step;

  // One restoring step: bring down the next dividend bit and try to subtract.
  // The partial remainder is always below the divisor, so after the shift it
  // is below 2*divisor and the truncated difference is exact when it is
  // non-negative.
  always_comb begin
    shifted   = {rem_reg, quo_reg[alu_width-1]};
    trial_neg = shifted < {2'b00, div_reg};
    diff      = shifted[alu_width:0] - {1'b0, div_reg};
    rem_next  = trial_neg ? shifted[alu_width:0] : diff;
    quo_next  = {quo_reg[alu_width-2:0], ~trial_neg};
    last_step = (cnt_reg == cnt_w'(1));
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath. A zero divisor needs no special case: every trial subtract
  // succeeds, so the quotient fills with ones and the remainder accumulates
  // the dividend unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      rem_reg <= '0;
      quo_reg <= '0;
      div_reg <= '0;
      o_data  <= '0;
      o_rem   <= '0;
      o_dbz   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            quo_reg <= i_data_a;
            div_reg <= i_data_b;
            rem_reg <= '0;
            cnt_reg <= cnt_w'(alu_width);
          end
        end
        RUN: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg - 1'b1;
          // Result registers only change on the final step, so they keep the
          // previous result while the next operation is in flight.
          if (last_step) begin
            o_data <= quo_next;
            o_rem  <= rem_next[alu_width-1:0];
            o_dbz  <= (div_reg == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div -- self-checking bench for seq_div (alu_width = 8)
// Inputs are driven and outputs sampled on the falling clock edge.
// Latency is counted in rising edges, starting with the accepting edge as 1.
// -----------------------------------------------------------------------------
module tb_seq_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] i_data_a = '0;
  logic [W-1:0] i_data_b = '0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic [W-1:0] o_rem;
  logic         o_valid;
  logic         o_dbz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_viol = 0;

  seq_div #(.alu_width(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_rem    (o_rem),
    .o_valid  (o_valid),
    .o_dbz    (o_dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Drive one operand strobe; called at a falling edge with the DUT idle.
  // Operands are scrambled afterwards to show they were latched.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    i_data_a = a;
    i_data_b = b;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    i_data_a = W'($urandom);
    i_data_b = W'($urandom);
  endtask

  // Wait (bounded) for o_valid. edges = rising edges since and including the
  // accepting edge, or -1 on timeout. Counts o_ready highs while waiting.
  task automatic wait_result(input int start, output int edges, output int at_cyc);
    edges  = start;
    at_cyc = -1;
    while (edges <= 30 && !o_valid) begin
      if (o_ready) ready_viol++;
      @(negedge clk);
      edges++;
    end
    if (o_valid) at_cyc = cyc;
    else edges = -1;
  endtask

  task automatic test_reset();
    i_valid  = 1'b1;
    i_data_a = 8'd100;
    i_data_b = 8'd7;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 8'd0 || o_rem !== 8'd0 || o_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b q=%0d r=%0d dbz=%b, expected 1 0 0 0 0",
               o_ready, o_valid, o_data, o_rem, o_dbz);
    end
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b ready=%b, expected 0 1", o_valid, o_ready);
    end
    $display("reset: outputs ready=%b q=%0d r=%0d", o_ready, o_data, o_rem);
  endtask

  task automatic test_basic();
    int e, c;
    ready_viol = 0;
    issue(8'd100, 8'd7);
    wait_result(1, e, c);
    n_checks++;
    if (e !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, expected 9", e);
    end
    n_checks++;
    if (o_data !== 8'd14 || o_rem !== 8'd2 || o_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, expected 14 2 0", o_data, o_rem, o_dbz);
    end
    n_checks++;
    if (ready_viol !== 0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_busy: got %0d ready cycles in RUN, ready=%b in DONE, expected 0 0",
               ready_viol, o_ready);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 8'd14 || o_rem !== 8'd2) begin
      n_fail++;
      $display("FAIL basic_after_done: got valid=%b ready=%b q=%0d r=%0d, expected 0 1 14 2",
               o_valid, o_ready, o_data, o_rem);
    end
    $display("op 100/7 -> q=14? %0d r=2? %0d latency %0d", o_data, o_rem, e);
  endtask

  task automatic test_corners();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic [W-1:0] tq [3];
    logic [W-1:0] tr [3];
    int e, c;
    ta = '{8'd255, 8'd5, 8'd255};
    tb = '{8'd1,   8'd9, 8'd255};
    tq = '{8'd255, 8'd0, 8'd1};
    tr = '{8'd0,   8'd5, 8'd0};
    for (int k = 0; k < 3; k++) begin
      issue(ta[k], tb[k]);
      wait_result(1, e, c);
      n_checks++;
      if (e !== 9 || o_data !== tq[k] || o_rem !== tr[k] || o_dbz !== 1'b0) begin
        n_fail++;
        $display("FAIL corner_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=0 lat=9",
                 k, ta[k], tb[k], o_data, o_rem, o_dbz, e, tq[k], tr[k]);
      end
      $display("op %0d/%0d -> q=%0d r=%0d", ta[k], tb[k], o_data, o_rem);
      @(negedge clk);
    end
  endtask

  task automatic test_dbz();
    int e, c;
    issue(8'd37, 8'd0);
    wait_result(1, e, c);
    n_checks++;
    if (e !== 9 || o_data !== 8'd255 || o_rem !== 8'd37 || o_dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b lat=%0d, expected 255 37 1 9",
               o_data, o_rem, o_dbz, e);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_one_cycle: got valid=%b, expected 0", o_valid);
    end
    $display("op 37/0 -> q=%0d r=%0d dbz=%b", o_data, o_rem, o_dbz);
  endtask

  task automatic test_ignore_valid();
    int e, c, extra;
    issue(8'd100, 8'd7);
    @(negedge clk);
    @(negedge clk);
    i_data_a = 8'd50;
    i_data_b = 8'd3;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    wait_result(4, e, c);
    n_checks++;
    if (e !== 9 || o_data !== 8'd14 || o_rem !== 8'd2) begin
      n_fail++;
      $display("FAIL ignore_result: got q=%0d r=%0d lat=%0d, expected 14 2 9", o_data, o_rem, e);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) extra++;
    end
    n_checks++;
    if (extra !== 0 || o_data !== 8'd14 || o_rem !== 8'd2) begin
      n_fail++;
      $display("FAIL ignore_no_extra: got %0d extra pulses q=%0d r=%0d, expected 0 14 2",
               extra, o_data, o_rem);
    end
    $display("op 100/7 with 50/3 pulsed in RUN -> q=%0d r=%0d extra=%0d", o_data, o_rem, extra);
  endtask

  task automatic test_reset_midrun();
    int e, c, pulses;
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_data !== 8'd0 || o_rem !== 8'd0 || o_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: got ready=%b valid=%b q=%0d r=%0d dbz=%b, expected 1 0 0 0 0",
               o_ready, o_valid, o_data, o_rem, o_dbz);
    end
    @(negedge clk);
    i_data_a = 8'd50;
    i_data_b = 8'd3;
    i_valid  = 1'b1;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_valid_in_reset: got ready=%b valid=%b, expected 1 0", o_ready, o_valid);
    end
    rst = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_no_pulse: got %0d pulses ready=%b, expected 0 1", pulses, o_ready);
    end
    issue(8'd200, 8'd16);
    wait_result(1, e, c);
    n_checks++;
    if (e !== 9 || o_data !== 8'd12 || o_rem !== 8'd8 || o_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_next_op: got q=%0d r=%0d dbz=%b lat=%0d, expected 12 8 0 9",
               o_data, o_rem, o_dbz, e);
    end
    $display("op 200/16 after reset -> q=%0d r=%0d", o_data, o_rem);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int e1, e2, c1, c2;
    issue(8'd100, 8'd7);
    wait_result(1, e1, c1);
    n_checks++;
    if (o_data !== 8'd14 || o_rem !== 8'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%0d r=%0d, expected 14 2", o_data, o_rem);
    end
    @(negedge clk);
    issue(8'd81, 8'd9);
    wait_result(1, e2, c2);
    n_checks++;
    if (o_data !== 8'd9 || o_rem !== 8'd0 || e2 !== 9) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, expected 9 0 9", o_data, o_rem, e2);
    end
    n_checks++;
    if (c1 < 0 || c2 < 0 || (c2 - c1) !== 10) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles between pulses, expected 10", c2 - c1);
    end
    $display("b2b 100/7 then 81/9 -> pulses %0d cycles apart, q=%0d r=%0d", c2 - c1, o_data, o_rem);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, exp_q, exp_r;
    logic exp_dbz;
    int e, c;
    for (int n = 0; n < 2000; n++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom_range(1, 255));
      exp_dbz = (b == 0);
      exp_q   = exp_dbz ? 8'd255 : W'(int'(a) / int'(b));
      exp_r   = exp_dbz ? a : W'(int'(a) % int'(b));
      issue(a, b);
      wait_result(1, e, c);
      n_checks++;
      if (e !== 9 || o_data !== exp_q || o_rem !== exp_r || o_dbz !== exp_dbz) begin
        n_fail++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d, expected q=%0d r=%0d dbz=%b lat=9",
                 n, a, b, o_data, o_rem, o_dbz, e, exp_q, exp_r, exp_dbz);
      end
      if (b != 0) begin
        n_checks++;
        if (int'(o_data) * int'(b) + int'(o_rem) !== int'(a) || o_rem >= b) begin
          n_fail++;
          $display("FAIL random_identity_%0d: %0d/%0d got q=%0d r=%0d, expected q*b+r=a with r<b",
                   n, a, b, o_data, o_rem);
        end
      end
      $display("op %0d/%0d -> q=%0d r=%0d dbz=%b", a, b, o_data, o_rem, o_dbz);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_dbz();
    test_ignore_valid();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
